// File: rtl/dcache_resp_buf.sv
// rtl/dcache_resp_buf.sv - dcache load response buffer (circular FIFO with per-entry kill)
// Optional same-cycle empty-buffer bypass selected by DCACHE_RESP_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LDQ_WIDTH
`define LDQ_WIDTH 3
`endif
`ifndef LDQ_DEPTH
`define LDQ_DEPTH 8
`endif

module dcache_resp_buf #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`XLEN-1:0]          dcache_data,
  input  logic [`LDQ_WIDTH-1:0]     dcache_ldq_tag,
  input  logic                      dcache_valid,
  output logic                      dcache_ready,
  input  logic [`LDQ_DEPTH-1:0]     fire_ld_kill,
  input  logic                      flush,
  output logic [`XLEN-1:0]          wb_data,
  output logic [`LDQ_WIDTH-1:0]     wb_ldq_tag,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [`XLEN-1:0]      data_q [DEPTH];
  logic [`LDQ_WIDTH-1:0] tag_q  [DEPTH];
  logic [DEPTH-1:0]      live_q;
  logic [AW-1:0]         head_q;
  logic [AW-1:0]         tail_q;
  logic [CW-1:0]         count_q;

  logic empty;
  logic full;
  logic head_live;
  logic ready_int;
  logic byp_take;
  logic push;
  logic pop;

  assign count = count_q;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL);
    head_live = !empty && live_q[head_q] && !fire_ld_kill[tag_q[head_q]];
    ready_int = !full && !flush;
`ifdef DCACHE_RESP_BYPASS_EN
    // An empty buffer hands the response straight through when the consumer is ready.
    byp_take  = empty && wb_ready;
`else
    byp_take  = 1'b0;
`endif
    push = dcache_valid && ready_int && !byp_take;
    // Dead heads drain one per cycle regardless of wb_ready.
    pop  = !flush && !empty && (!head_live || wb_ready);
  end

  always_comb begin
    dcache_ready = 1'b0;
    wb_valid     = 1'b0;
    wb_data      = '0;
    wb_ldq_tag   = '0;
    if (!rst) begin
      dcache_ready = ready_int;
`ifdef DCACHE_RESP_BYPASS_EN
      if (empty) begin
        wb_valid   = dcache_valid && !fire_ld_kill[dcache_ldq_tag] && !flush;
        wb_data    = dcache_data;
        wb_ldq_tag = dcache_ldq_tag;
      end else begin
        wb_valid   = head_live && !flush;
        wb_data    = data_q[head_q];
        wb_ldq_tag = tag_q[head_q];
      end
`else
      wb_valid   = head_live && !flush;
      wb_data    = data_q[head_q];
      wb_ldq_tag = tag_q[head_q];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= live_q[i] && !fire_ld_kill[tag_q[i]];
      end
      if (push) begin
        live_q[tail_q] <= !fire_ld_kill[dcache_ldq_tag];
        tail_q         <= tail_q + AW'(1);
      end
      if (pop) begin
        head_q <= head_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= dcache_data;
      tag_q[tail_q]  <= dcache_ldq_tag;
    end
  end

endmodule

// File: doc/dcache_resp_buf.md
DCACHE_RESP_BUF -- requirements
Module: dcache_resp_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered load responses (power of two, at least 2).
REQ-002 The block SHALL use the macros `XLEN, `LDQ_WIDTH and `LDQ_DEPTH for its widths.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port dcache_data, input, `XLEN bits: load data returned by the dcache.
REQ-006 The block SHALL have port dcache_ldq_tag, input, `LDQ_WIDTH bits: the LDQ index of the returned load.
REQ-007 The block SHALL have port dcache_valid, input, 1 bit: a dcache response is present.
REQ-008 The block SHALL have port dcache_ready, output, 1 bit: the buffer accepts a response.
REQ-009 The block SHALL have port fire_ld_kill, input, `LDQ_DEPTH bits: per-LDQ-entry kill bitmap.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all buffered responses.
REQ-011 The block SHALL have port wb_data, output, `XLEN bits: writeback data to the LDQ/ROB.
REQ-012 The block SHALL have port wb_ldq_tag, output, `LDQ_WIDTH bits: the LDQ index for the writeback.
REQ-013 The block SHALL have port wb_valid, output, 1 bit: the writeback is valid.
REQ-014 The block SHALL have port wb_ready, input, 1 bit: the consumer accepts the writeback.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of occupied slots.

Function
REQ-016 The block SHALL implement a circular FIFO of DEPTH slots; each slot holds data, tag and a live bit; the pointers SHALL wrap modulo DEPTH.
REQ-017 The block SHALL drive dcache_ready = (count != DEPTH) && !flush, a function of registered state and flush only, with no dependence on wb_ready.
REQ-018 A push SHALL occur when dcache_valid && dcache_ready; the slot's live bit SHALL be written as !fire_ld_kill[dcache_ldq_tag], so a response killed in the same cycle is accepted but dead.
REQ-019 Every cycle, the block SHALL clear the live bit of each occupied slot whose tag has fire_ld_kill[tag]=1.
REQ-020 The head SHALL be effective-live when count != 0, its live bit is 1, and fire_ld_kill[head tag]=0.
REQ-021 The block SHALL drive wb_valid = effective-live head && !flush, with wb_data and wb_ldq_tag taken from the head slot; the outputs SHALL not depend on wb_ready.
REQ-022 A pop SHALL occur on (wb_valid && wb_ready), or when count != 0 and the head is not effective-live; a dead-head pop drains one slot per cycle and SHALL not assert wb_valid.
REQ-023 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full, no push SHALL occur; a pop in the same cycle SHALL raise dcache_ready on the next cycle, not the same cycle.
REQ-025 When flush=1, all pointers and count SHALL be zero on the next edge, and no push or writeback SHALL occur in that cycle.
REQ-026 Latency without bypass SHALL be: response accepted in cycle N, earliest wb_valid in cycle N+1.
REQ-027 Responses SHALL be written back in acceptance order; dead entries SHALL never appear on wb_*.

Reset
REQ-028 While rst=1, asynchronously: pointers=0, count=0, all live bits=0, wb_valid=0, dcache_ready=0, wb_data=0, wb_ldq_tag=0.
REQ-029 After rst deasserts, dcache_ready SHALL be 1 from the first clk edge.
REQ-030 A reset asserted mid-operation SHALL discard all buffered entries with no partial writeback.

Configuration
REQ-031 The macro DCACHE_RESP_BYPASS_EN SHALL select bypass behaviour.
- Defined: when count==0, wb_valid = dcache_valid && !fire_ld_kill[dcache_ldq_tag] && !flush, with wb_data and wb_ldq_tag taken from the dcache inputs.
- Defined, wb_ready=1 in that cycle: no enqueue occurs; otherwise the response is enqueued per REQ-018.
- Not defined: all responses go through the FIFO (REQ-026), with no combinational dcache-to-wb path.

Verification
REQ-032 Push tag 3, data 0xDEADBEEF, wb_ready=1, no bypass -> wb_valid in the next cycle with tag 3, data 0xDEADBEEF; count goes 1 then 0.
REQ-033 wb_ready=0, push 4 responses (DEPTH=4) -> count=4, dcache_ready=0; raise wb_ready -> tags drain in order; dcache_ready=1 the cycle after the first pop.
REQ-034 Buffer tags 1,2,5; pulse fire_ld_kill[2] -> only tags 1 and 5 are written back; tag 2 is silently drained.
REQ-035 Push tag 6 with fire_ld_kill[6]=1 in the same cycle -> accepted (count=1) and never seen on wb_valid.
REQ-036 3 entries buffered, assert flush for 1 cycle -> count=0 next cycle; wb_valid=0 and dcache_ready=0 during the flush cycle.
REQ-037 With DCACHE_RESP_BYPASS_EN, empty buffer, wb_ready=1, push tag 7 -> wb_valid in the same cycle with tag 7 and count stays 0.
